eink_scan_ctrl: RTL and testbench

EINK_SCAN_CTRL -- requirements
Module: eink_scan_ctrl

---
 rtl/eink_scan_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_eink_scan_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/eink_scan_ctrl.sv
// E-ink panel scan controller: walks source ticks and gate lines per frame,
// fetching pixel bytes and driving the source/gate driver strobes.
module eink_scan_ctrl #(
  parameter int SRC_BYTES = 200,
  parameter int GATES     = 600,
  parameter int SRC_FP    = 6,
  parameter int GATE_FP   = 14,
  parameter int DW        = 8,
  parameter int CL_DIV    = 1,
  parameter int PW        = 7,
  parameter int AW        = 17
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [PW-1:0] phase_count,
  input  logic          abort,
  output logic          ready,
  output logic [PW-1:0] phase,
  output logic          frame_done,
  output logic [AW-1:0] addr,
  input  logic [DW-1:0] pix_in,
  output logic [DW-1:0] data,
  input  logic          clip_en,
  input  logic [7:0]    clip_x1,
  input  logic [7:0]    clip_x2,
  input  logic [9:0]    clip_y1,
  input  logic [9:0]    clip_y2,
  output logic          cl,
  output logic          sph,
  output logic          le,
  output logic          ckv,
  output logic          spv,
  output logic          oe,
  output logic          gmode
);

  localparam int SMAX = SRC_BYTES + SRC_FP - 1;
  localparam int GMAX = GATES + GATE_FP;
  localparam int TMAX = 2 * CL_DIV - 1;
  localparam int SW   = $clog2(SMAX + 1);
  localparam int GW   = $clog2(GMAX + 1);
  localparam int CW   = (TMAX > 0) ? $clog2(TMAX + 1) : 1;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_RUN  = 1'b1;

  logic          state;
  logic [CW-1:0] cc;
  logic [SW-1:0] s;
  logic [GW-1:0] g;
  logic [PW-1:0] pc_q;
  logic          clip_en_q;
  logic [7:0]    cx1, cx2;
  logic [9:0]    cy1, cy2;
  logic          abort_pend;

  logic          go, tick_end, line_end, frame_end, last_frame, stop_now;
  logic          cur_data_row, cur_skip, nxt_data_row, nxt_skip, col_ok;
  logic [CW-1:0] ncc;
  logic [SW-1:0] ns;
  logic [GW-1:0] ng;
  logic [AW-1:0] n_addr;
  logic          n_sph, n_le, n_ckv, n_spv;

  assign ready = (state == ST_IDLE);

  always_comb begin
    go         = (state == ST_IDLE) && start && (phase_count != '0);
    tick_end   = (state == ST_RUN) && (int'(cc) == TMAX);
    ncc        = tick_end ? '0 : cc + 1'b1;
    line_end   = (int'(s) == SMAX);
    frame_end  = line_end && (int'(g) == GMAX);
    last_frame = ((phase + 1'b1) == pc_q);
    stop_now   = abort || abort_pend;

    cur_data_row = (g != '0) && (int'(g) <= GATES);
    cur_skip     = cur_data_row && clip_en_q &&
                   ((int'(g) - 1 < int'(cy1)) || (int'(g) - 1 > int'(cy2)));
    col_ok       = cur_data_row && !cur_skip && (int'(s) < SRC_BYTES) &&
                   (!clip_en_q || ((int'(s) >= int'(cx1)) && (int'(s) <= int'(cx2))));

    // Position of the tick about to start; IDLE always launches at g=0, s=0.
    if (state == ST_IDLE) begin
      ns = '0;
      ng = '0;
    end else if (line_end) begin
      ns = '0;
      ng = frame_end ? '0 : g + 1'b1;
    end else begin
      ng = g;
      ns = (s == '0 && cur_skip) ? SW'(SRC_BYTES + 1) : s + 1'b1;
    end

    nxt_data_row = (ng != '0) && (int'(ng) <= GATES);
    nxt_skip     = nxt_data_row && clip_en_q &&
                   ((int'(ng) - 1 < int'(cy1)) || (int'(ng) - 1 > int'(cy2)));

    n_spv  = (ng != '0);
    n_sph  = !(nxt_data_row && !nxt_skip && (ns != '0) && (int'(ns) <= SRC_BYTES));
    n_le   = nxt_data_row && !nxt_skip && (int'(ns) == SRC_BYTES + 2);
    n_ckv  = (int'(ns) >= SRC_BYTES + 3);
    n_addr = '0;
    if (nxt_data_row && !nxt_skip && (int'(ns) < SRC_BYTES))
      n_addr = AW'(ng - 1'b1) * AW'(SRC_BYTES) + AW'(ns);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      cc         <= '0;
      s          <= '0;
      g          <= '0;
      pc_q       <= '0;
      clip_en_q  <= 1'b0;
      cx1        <= '0;
      cx2        <= '0;
      cy1        <= '0;
      cy2        <= '0;
      abort_pend <= 1'b0;
      phase      <= '0;
      frame_done <= 1'b0;
      addr       <= '0;
      data       <= '0;
      cl         <= 1'b0;
      sph        <= 1'b1;
      le         <= 1'b0;
      ckv        <= 1'b0;
      spv        <= 1'b1;
      oe         <= 1'b0;
      gmode      <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (state == ST_IDLE) begin
        if (go) begin
          state      <= ST_RUN;
          pc_q       <= phase_count;
          clip_en_q  <= clip_en;
          cx1        <= clip_x1;
          cx2        <= clip_x2;
          cy1        <= clip_y1;
          cy2        <= clip_y2;
          abort_pend <= 1'b0;
          phase      <= '0;
          cc         <= '0;
          s          <= '0;
          g          <= '0;
          addr       <= n_addr;
          data       <= '0;
          cl         <= 1'b0;
          sph        <= n_sph;
          le         <= n_le;
          ckv        <= n_ckv;
          spv        <= n_spv;
          oe         <= 1'b1;
          gmode      <= 1'b1;
        end
      end else if (!tick_end) begin
        cc <= ncc;
        cl <= (int'(ncc) >= CL_DIV);
        if (abort) abort_pend <= 1'b1;
      end else if (stop_now || (frame_end && last_frame)) begin
        // Abort wins over a coincident frame end, so it never emits frame_done.
        frame_done <= !stop_now;
        state      <= ST_IDLE;
        abort_pend <= 1'b0;
        phase      <= '0;
        cc         <= '0;
        s          <= '0;
        g          <= '0;
        addr       <= '0;
        data       <= '0;
        cl         <= 1'b0;
        sph        <= 1'b1;
        le         <= 1'b0;
        ckv        <= 1'b0;
        spv        <= 1'b1;
        oe         <= 1'b0;
        gmode      <= 1'b0;
      end else begin
        cc    <= '0;
        cl    <= 1'b0;
        s     <= ns;
        g     <= ng;
        addr  <= n_addr;
        data  <= col_ok ? pix_in : '0;
        sph   <= n_sph;
        le    <= n_le;
        ckv   <= n_ckv;
        spv   <= n_spv;
        if (frame_end) begin
          phase      <= phase + 1'b1;
          frame_done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_eink_scan_ctrl.sv
// Bench for eink_scan_ctrl: table of scan sequences checked tick-by-tick
// against a queued reference, plus abort, zero-phase start and reset cases.
module tb_eink_scan_ctrl;

  localparam int SB  = 4;
  localparam int GT  = 3;
  localparam int SFP = 6;
  localparam int GFP = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [6:0]  phase_count = '0;
  logic        clip_en = 1'b0;
  logic [7:0]  clip_x1 = '0, clip_x2 = '0;
  logic [9:0]  clip_y1 = '0, clip_y2 = '0;
  logic        ready, frame_done, cl, sph, le, ckv, spv, oe, gmode;
  logic [6:0]  phase;
  logic [16:0] addr;
  logic [7:0]  data, pix_in;

  assign pix_in = addr[7:0];

  always #5 clk = ~clk;

  eink_scan_ctrl #(
    .SRC_BYTES(SB), .GATES(GT), .SRC_FP(SFP), .GATE_FP(GFP),
    .DW(8), .CL_DIV(1), .PW(7), .AW(17)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .phase_count(phase_count), .abort(abort),
    .ready(ready), .phase(phase), .frame_done(frame_done), .addr(addr),
    .pix_in(pix_in), .data(data), .clip_en(clip_en), .clip_x1(clip_x1),
    .clip_x2(clip_x2), .clip_y1(clip_y1), .clip_y2(clip_y2), .cl(cl), .sph(sph),
    .le(le), .ckv(ckv), .spv(spv), .oe(oe), .gmode(gmode)
  );

  typedef struct packed {
    logic        ready;
    logic [6:0]  phase;
    logic        fd;
    logic [16:0] addr;
    logic [7:0]  data;
    logic        sph, le, ckv, spv, oe, gmode, cl;
  } obs_t;

  typedef struct {
    int pc;
    bit ce;
    int x1, x2, y1, y2;
    int n_fd, n_le, n_ticks;
  } case_t;

  localparam obs_t IDLE_OBS = '{ready: 1'b1, phase: 7'd0, fd: 1'b0, addr: 17'd0,
                                data: 8'd0, sph: 1'b1, le: 1'b0, ckv: 1'b0,
                                spv: 1'b1, oe: 1'b0, gmode: 1'b0, cl: 1'b0};

  obs_t  q[$];
  case_t cases[5];
  int    checks = 0;
  int    failures = 0;

  function automatic obs_t sample();
    obs_t o;
    o = '{ready: ready, phase: phase, fd: frame_done, addr: addr, data: data,
          sph: sph, le: le, ckv: ckv, spv: spv, oe: oe, gmode: gmode, cl: cl};
    return o;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference sequence of per-tick outputs derived from the scan rules.
  task automatic build_exp(input case_t c);
    obs_t e;
    int   prev, r, s;
    bit   drow, skip;
    prev = 0;
    for (int f = 0; f < c.pc; f++) begin
      for (int g = 0; g <= GT + GFP; g++) begin
        drow = (g >= 1) && (g <= GT);
        r    = g - 1;
        skip = drow && c.ce && ((r < c.y1) || (r > c.y2));
        s    = 0;
        while (1) begin
          e.ready = 1'b0;
          e.phase = 7'(f);
          e.fd    = (f > 0) && (g == 0) && (s == 0);
          e.addr  = (drow && !skip && s < SB) ? 17'(r * SB + s) : 17'd0;
          e.data  = 8'(prev);
          e.sph   = !(drow && !skip && s >= 1 && s <= SB);
          e.le    = drow && !skip && (s == SB + 2);
          e.ckv   = (s >= SB + 3);
          e.spv   = (g != 0);
          e.oe    = 1'b1;
          e.gmode = 1'b1;
          e.cl    = 1'b0;
          q.push_back(e);
          prev = (drow && !skip && s < SB && (!c.ce || (s >= c.x1 && s <= c.x2))) ? r * SB + s : 0;
          if (s == SB + SFP - 1) break;
          s = (s == 0 && skip) ? SB + 1 : s + 1;
        end
      end
    end
    e = IDLE_OBS;
    e.fd = 1'b1;
    q.push_back(e);
  endtask

  task automatic run_case(input int idx, input case_t c);
    obs_t a, e;
    int   nle, nfd, nt, t;
    q.delete();
    build_exp(c);
    @(negedge clk);
    clip_en = c.ce;
    clip_x1 = 8'(c.x1);
    clip_x2 = 8'(c.x2);
    clip_y1 = 10'(c.y1);
    clip_y2 = 10'(c.y2);
    phase_count = 7'(c.pc);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    nle = 0; nfd = 0; nt = 0; t = 0;
    while (q.size() > 0) begin
      e = q.pop_front();
      a = sample();
      chk($sformatf("case%0d_tick%0d", idx, t), 64'(a), 64'(e));
      if (a.le) nle++;
      if (a.fd) nfd++;
      if (!a.ready) nt++;
      if (!e.ready) begin
        @(posedge clk);
        #1 chk($sformatf("case%0d_tick%0d_cl", idx, t), 64'(cl), 64'(1'b1));
        @(posedge clk);
        #1;
      end
      t++;
    end
    chk($sformatf("case%0d_le_count", idx), 64'(nle), 64'(c.n_le));
    chk($sformatf("case%0d_fd_count", idx), 64'(nfd), 64'(c.n_fd));
    chk($sformatf("case%0d_tick_count", idx), 64'(nt), 64'(c.n_ticks));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nfd;
    cases[0] = '{pc: 1, ce: 0, x1: 0, x2: 0, y1: 0, y2: 0, n_fd: 1, n_le: 3, n_ticks: 60};
    cases[1] = '{pc: 2, ce: 0, x1: 0, x2: 0, y1: 0, y2: 0, n_fd: 2, n_le: 6, n_ticks: 120};
    cases[2] = '{pc: 1, ce: 1, x1: 2, x2: 2, y1: 1, y2: 1, n_fd: 1, n_le: 1, n_ticks: 52};
    cases[3] = '{pc: 1, ce: 1, x1: 3, x2: 0, y1: 0, y2: 2, n_fd: 1, n_le: 3, n_ticks: 60};
    cases[4] = '{pc: 1, ce: 1, x1: 0, x2: 3, y1: 2, y2: 0, n_fd: 1, n_le: 0, n_ticks: 48};

    #2 rst = 1'b1;
    #1 chk("reset_state", 64'(sample()), 64'(IDLE_OBS));
    repeat (3) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) run_case(i, cases[i]);

    // Abort during g=2, s=3 (tick 23 of the frame).
    @(negedge clk);
    clip_en = 1'b0;
    phase_count = 7'd1;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (46) @(posedge clk);
    #1 chk("abort_pos_g2s3", 64'({sph, spv, addr}), 64'({1'b0, 1'b1, 17'd7}));
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    chk("abort_holds_mid_tick", 64'(oe), 64'(1'b1));
    @(posedge clk);
    #1 chk("abort_idle", 64'(sample()), 64'(IDLE_OBS));
    nfd = 0;
    repeat (50) begin
      @(posedge clk);
      #1 if (frame_done) nfd++;
    end
    chk("abort_no_frame_done", 64'(nfd), 64'(0));

    @(negedge clk);
    phase_count = 7'd0;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #1 chk("zero_phase_ignored", 64'({ready, oe}), 64'({1'b1, 1'b0}));

    // Reset mid-frame, then a fresh sequence must start from g=0.
    @(negedge clk);
    phase_count = 7'd1;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (30) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1 chk("midframe_reset", 64'(sample()), 64'(IDLE_OBS));
    @(negedge clk);
    rst = 1'b0;
    run_case(5, cases[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
